// File: rtl/rx_byte_fifo.sv
// Receive-side first-word-fall-through byte FIFO sitting behind the serial receiver.
// Buffers bytes while the consumer is busy; reports occupancy and sticky over/underflow.
module rx_byte_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        din,
  input  logic              load,
  input  logic              rd_en,
  input  logic              clear,
  output logic [7:0]        dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_accept, rd_accept;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts load with rd_en.
  assign wr_accept = !clear && load && (!full || rd_en);
  assign rd_accept = !clear && rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_accept) rd_ptr_d = rd_ptr_q + PtrOne;
      if (wr_accept && !rd_accept) begin
        count_d = count_q + CountOne;
      end else if (rd_accept && !wr_accept) begin
        count_d = count_q - CountOne;
      end
      if (load && full && !rd_en) overflow_d = 1'b1;
      if (rd_en && empty)         underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= din;
  end

  assign dout      = empty ? 8'h00 : mem[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo: scoreboard queue of expected bytes plus a
// small occupancy/flag model, compared one cycle after every stimulus edge.
module tb_rx_byte_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       load;
  logic       rd_en;
  logic       clear;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  rx_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .load      (load),
    .rd_en     (rd_en),
    .clear     (clear),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_bad;

  logic [7:0] exp_q[$];
  int         m_count;
  logic       m_ovf;
  logic       m_udf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    check({tag, ".full"}, 32'(full), 32'(m_count == DEPTH));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".udf"}, 32'(underflow), 32'(m_udf));
    check({tag, ".dout"}, 32'(dout), (exp_q.size() == 0) ? 32'h0 : 32'(exp_q[0]));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock cycle of stimulus; the model is advanced and the DUT checked afterwards.
  task automatic cyc(input string tag, input logic l, input logic [7:0] d, input logic r,
                     input logic c);
    logic m_full, m_empty, rd_ok, wr_ok;
    load  = l;
    din   = d;
    rd_en = r;
    clear = c;
    m_full  = (m_count == DEPTH);
    m_empty = (m_count == 0);
    if (c) begin
      model_reset();
    end else begin
      rd_ok = r && !m_empty;
      wr_ok = l && (!m_full || r);
      if (rd_ok) check({tag, ".pop"}, 32'(dout), 32'(exp_q.pop_front()));
      if (wr_ok) exp_q.push_back(d);
      if (wr_ok && !rd_ok) m_count++;
      if (rd_ok && !wr_ok) m_count--;
      if (l && m_full && !r) m_ovf = 1'b1;
      if (r && m_empty) m_udf = 1'b1;
    end
    @(posedge clk);
    #1;
    load  = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
    din   = 8'h00;
    check_state(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    reset = 1'b0;
    din   = 8'h00;
    load  = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("rst");
    reset = 1'b1;
    cyc("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Basic ordering
    cyc("ldA5", 1'b1, 8'hA5, 1'b0, 1'b0);
    cyc("ld3C", 1'b1, 8'h3C, 1'b0, 1'b0);
    check("two.count", 32'(count), 32'd2);
    check("two.dout", 32'(dout), 32'hA5);
    cyc("rd1", 1'b0, 8'h00, 1'b1, 1'b0);
    check("rd1.dout", 32'(dout), 32'h3C);
    cyc("rd2", 1'b0, 8'h00, 1'b1, 1'b0);
    check("rd2.dout", 32'(dout), 32'h00);

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("fill.full", 32'(full), 32'd1);
    cyc("ovf", 1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf.flag", 32'(overflow), 32'd1);
    check("ovf.count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc("clr1", 1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous load and read at full
    for (int i = 0; i < 16; i++) cyc("fill2", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc("fullrw", 1'b1, 8'h77, 1'b1, 1'b0);
    check("fullrw.count", 32'(count), 32'd16);
    check("fullrw.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 15; i++) cyc("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
    check("last77", 32'(dout), 32'h77);
    cyc("drain2l", 1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow
    cyc("udf", 1'b0, 8'h00, 1'b1, 1'b0);
    check("udf.flag", 32'(underflow), 32'd1);
    cyc("clr2", 1'b1, 8'h99, 1'b1, 1'b1);
    check("clr2.udf", 32'(underflow), 32'd0);
    cyc("udfld", 1'b1, 8'h11, 1'b1, 1'b0);
    check("udfld.dout", 32'(dout), 32'h11);
    check("udfld.udf", 32'(underflow), 32'd1);
    cyc("clr3", 1'b0, 8'h00, 1'b0, 1'b1);

    // Pointer wrap
    for (int i = 0; i < 40; i++) begin
      cyc("wrapw", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      cyc("wrapr", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-stream
    cyc("pre1", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc("pre2", 1'b1, 8'h5A, 1'b0, 1'b0);
    cyc("pre3", 1'b1, 8'h6B, 1'b0, 1'b0);
    load = 1'b1;
    din  = 8'h7C;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_state("arst");
    load = 1'b0;
    din  = 8'h00;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state("post");
    cyc("postld", 1'b1, 8'hC3, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
